// File: rtl/taxi_req_arbiter.sv
// taxi_req_arbiter: registered N-way request arbiter with a one-hot grant,
// a valid flag and the binary index of the granted port. It supports fixed
// priority or round-robin selection. A grant can optionally be held until
// the owner drops its request or acknowledges.
module taxi_req_arbiter #(
  parameter int PORTS           = 4,
  parameter int ARB_ROUND_ROBIN = 0,
  parameter int ARB_BLOCK       = 0,
  parameter int ARB_BLOCK_ACK   = 1,
  parameter int LSB_HIGH_PRIO   = 0,
  localparam int IDX_W          = (PORTS > 1) ? $clog2(PORTS) : 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [PORTS-1:0] req,
  input  logic [PORTS-1:0] ack,
  output logic [PORTS-1:0] grant,
  output logic             grant_valid,
  output logic [IDX_W-1:0] grant_index
);

  logic [PORTS-1:0] grant_r;
  logic             grant_valid_r;
  logic [IDX_W-1:0] grant_index_r;
  logic [PORTS-1:0] mask_r;

  logic             hold_s;
  logic [PORTS-1:0] masked_s;
  logic [IDX_W-1:0] win_idx_s;

  // Priority pick: index of the highest-priority set bit (0 when none set).
  function automatic logic [IDX_W-1:0] prio_pick(input logic [PORTS-1:0] vec);
    logic [IDX_W-1:0] idx;
    idx = {IDX_W{1'b0}};
    if (LSB_HIGH_PRIO != 0) begin
      for (int i = PORTS - 1; i >= 0; i--) idx = vec[i] ? IDX_W'(i) : idx;
    end else begin
      for (int i = 0; i < PORTS; i++) idx = vec[i] ? IDX_W'(i) : idx;
    end
    return idx;
  endfunction

  // Round-robin mask after granting port k: only ports "after" k stay eligible.
  function automatic logic [PORTS-1:0] rr_mask(input logic [IDX_W-1:0] k);
    logic [PORTS-1:0] m;
    for (int j = 0; j < PORTS; j++) begin
      m[j] = (LSB_HIGH_PRIO != 0) ? (j > int'(k)) : (j < int'(k));
    end
    return m;
  endfunction

  // One-hot decode of a port index.
  function automatic logic [PORTS-1:0] onehot(input logic [IDX_W-1:0] k);
    logic [PORTS-1:0] v;
    for (int j = 0; j < PORTS; j++) v[j] = (int'(k) == j);
    return v;
  endfunction

  // Decide whether the current owner keeps its grant, and pick the next winner.
  always_comb begin
    hold_s    = 1'b0;
    masked_s  = req & mask_r;
    win_idx_s = {IDX_W{1'b0}};
    if (ARB_BLOCK != 0 && ARB_BLOCK_ACK == 0) begin
      hold_s = ((grant_r & req) != {PORTS{1'b0}});
    end else if (ARB_BLOCK != 0) begin
      hold_s = grant_valid_r && ((grant_r & ack) == {PORTS{1'b0}});
    end else begin
      hold_s = 1'b0;
    end
    if (ARB_ROUND_ROBIN != 0 && masked_s != {PORTS{1'b0}}) begin
      win_idx_s = prio_pick(masked_s);
    end else begin
      win_idx_s = prio_pick(req);
    end
  end

  // Grant registers and round-robin mask; a held grant keeps the mask unchanged.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grant_r       <= {PORTS{1'b0}};
      grant_valid_r <= 1'b0;
      grant_index_r <= {IDX_W{1'b0}};
      mask_r        <= {PORTS{1'b0}};
    end else if (hold_s) begin
      grant_r       <= grant_r;
      grant_valid_r <= grant_valid_r;
      grant_index_r <= grant_index_r;
      mask_r        <= mask_r;
    end else if (req != {PORTS{1'b0}}) begin
      grant_r       <= onehot(win_idx_s);
      grant_valid_r <= 1'b1;
      grant_index_r <= win_idx_s;
      if (ARB_ROUND_ROBIN != 0) begin
        mask_r <= rr_mask(win_idx_s);
      end else begin
        mask_r <= mask_r;
      end
    end else begin
      grant_r       <= {PORTS{1'b0}};
      grant_valid_r <= 1'b0;
      grant_index_r <= {IDX_W{1'b0}};
      mask_r        <= mask_r;
    end
  end

  assign grant       = grant_r;
  assign grant_valid = grant_valid_r;
  assign grant_index = grant_index_r;

endmodule

// File: tb/tb_taxi_req_arbiter.sv
// Bench for taxi_req_arbiter: three instances share req/ack.
//   u0: round-robin, ack-blocking, port 0 highest
//   u1: fixed priority, non-blocking, port 0 highest
//   u2: fixed priority, non-blocking, port 3 highest
// An owner/last-winner model predicts every instance each cycle.
module tb_taxi_req_arbiter;

  localparam logic [2:0] CFG_RR  = 3'b001;
  localparam logic [2:0] CFG_BLK = 3'b001;
  localparam logic [2:0] CFG_ACK = 3'b001;
  localparam logic [2:0] CFG_LSB = 3'b011;

  logic       clk;
  logic       rst_n;
  logic [3:0] req;
  logic [3:0] ack;
  logic [3:0] d_grant [3];
  logic       d_valid [3];
  logic [1:0] d_idx   [3];

  int vectors;
  int miscompares;
  bit cmp_en;

  int m_owner [3];
  int m_last  [3];

  taxi_req_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(1), .ARB_BLOCK(1), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIO(1)) u0 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .grant(d_grant[0]), .grant_valid(d_valid[0]), .grant_index(d_idx[0]));
  taxi_req_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIO(1)) u1 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .grant(d_grant[1]), .grant_valid(d_valid[1]), .grant_index(d_idx[1]));
  taxi_req_arbiter #(.PORTS(4), .ARB_ROUND_ROBIN(0), .ARB_BLOCK(0), .ARB_BLOCK_ACK(1), .LSB_HIGH_PRIO(0)) u2 (
    .clk(clk), .rst_n(rst_n), .req(req), .ack(ack),
    .grant(d_grant[2]), .grant_valid(d_valid[2]), .grant_index(d_idx[2]));

  // Clock generation.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Winner selection from the rules: a fixed search order or a rotation after the last winner.
  function automatic int pick(input logic [3:0] r, input bit rr, input bit lsb, input int last);
    int k;
    for (int s = 0; s < 4; s++) begin
      if (!rr) k = lsb ? s : 3 - s;
      else if (lsb) k = (last + 1 + s + 8) % 4;
      else k = (last - 1 - s + 8) % 4;
      if (r[k]) return k;
    end
    return -1;
  endfunction

  // Behavioural model: which port owns the grant and who won last.
  always @(posedge clk or negedge rst_n) begin : model
    if (!rst_n) begin
      for (int i = 0; i < 3; i++) begin
        m_owner[i] <= -1;
        m_last[i]  <= CFG_LSB[i] ? -1 : 4;
      end
    end else begin
      for (int i = 0; i < 3; i++) begin
        automatic int  o    = m_owner[i];
        automatic bit  hold = 1'b0;
        automatic int  w;
        if (CFG_BLK[i] && !CFG_ACK[i] && o >= 0 && req[o]) hold = 1'b1;
        if (CFG_BLK[i] && CFG_ACK[i] && o >= 0 && !ack[o]) hold = 1'b1;
        if (!hold) begin
          if (req == 4'b0000) begin
            m_owner[i] <= -1;
          end else begin
            w = pick(req, CFG_RR[i], CFG_LSB[i], m_last[i]);
            m_owner[i] <= w;
            if (CFG_RR[i]) m_last[i] <= w;
          end
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Per-cycle compare of every instance against the model.
  always @(negedge clk) begin : compare
    if (cmp_en) begin
      for (int i = 0; i < 3; i++) begin
        automatic int o = m_owner[i];
        automatic logic [3:0] eg = (o >= 0) ? (4'b0001 << o) : 4'b0000;
        automatic logic [1:0] ei = (o >= 0) ? 2'(o) : 2'd0;
        chk($sformatf("model_grant_u%0d", i), {28'd0, d_grant[i]}, {28'd0, eg});
        chk($sformatf("model_valid_u%0d", i), {31'd0, d_valid[i]}, {31'd0, (o >= 0)});
        chk($sformatf("model_index_u%0d", i), {30'd0, d_idx[i]}, {30'd0, ei});
      end
    end
  end

  // Drive inputs at a falling edge; outputs are checked one cycle later.
  task automatic apply(input logic [3:0] r, input logic [3:0] a);
    req = r;
    ack = a;
    @(negedge clk);
  endtask

  task automatic lit(input string name, input int u, input logic [3:0] g, input logic v, input logic [1:0] x);
    chk({name, "_grant"}, {28'd0, d_grant[u]}, {28'd0, g});
    chk({name, "_valid"}, {31'd0, d_valid[u]}, {31'd0, v});
    chk({name, "_index"}, {30'd0, d_idx[u]}, {30'd0, x});
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    cmp_en = 1'b0;
    rst_n = 1'b0;
    req = 4'b0000;
    ack = 4'b0000;
    repeat (2) @(negedge clk);
    lit("reset", 0, 4'b0000, 1'b0, 2'd0);
    rst_n = 1'b1;
    cmp_en = 1'b1;
    @(negedge clk);

    apply(4'b0010, 4'b0000);
    lit("single_req_u0", 0, 4'b0010, 1'b1, 2'd1);
    apply(4'b0000, 4'b0000);
    lit("held_no_ack", 0, 4'b0010, 1'b1, 2'd1);
    lit("nonblock_drop", 1, 4'b0000, 1'b0, 2'd0);

    // Asynchronous reset while a grant is held.
    #2 rst_n = 1'b0;
    #1 lit("async_reset", 0, 4'b0000, 1'b0, 2'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Round-robin with ack on each grant: 0,1,2,3,0.
    apply(4'b1111, 4'b0000);
    lit("rr_first", 0, 4'b0001, 1'b1, 2'd0);
    apply(4'b1111, 4'b0001);
    lit("rr_second", 0, 4'b0010, 1'b1, 2'd1);
    apply(4'b1111, 4'b0010);
    lit("rr_third", 0, 4'b0100, 1'b1, 2'd2);
    apply(4'b1111, 4'b0100);
    lit("rr_fourth", 0, 4'b1000, 1'b1, 2'd3);
    apply(4'b1111, 4'b1000);
    lit("rr_wrap", 0, 4'b0001, 1'b1, 2'd0);

    // Ack on a non-granted port is ignored.
    apply(4'b0101, 4'b0100);
    lit("foreign_ack", 0, 4'b0001, 1'b1, 2'd0);
    apply(4'b0101, 4'b0001);
    lit("ack_rearb", 0, 4'b0100, 1'b1, 2'd2);
    lit("fixed_lsb_0101", 1, 4'b0001, 1'b1, 2'd0);

    // Fixed priority in both directions.
    apply(4'b1010, 4'b0100);
    lit("fixed_lsb_1010", 1, 4'b0010, 1'b1, 2'd1);
    lit("fixed_msb_1010", 2, 4'b1000, 1'b1, 2'd3);
    lit("rr_after_ack", 0, 4'b1000, 1'b1, 2'd3);
    apply(4'b0000, 4'b1000);
    lit("idle_u0", 0, 4'b0000, 1'b0, 2'd0);
    apply(4'b0110, 4'b0000);
    apply(4'b0110, 4'b0000);
    apply(4'b0001, 4'b0100);
    apply(4'b0000, 4'b0000);

    cmp_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
